// File: rtl/alu_io_frontend.sv
// Pad-side front end for the dual 4-bit ALU macro: synchronises and debounces the operand
// pins, issues one operation per stable change, and holds the returned result on the pads.
module alu_io_frontend #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [19:0] io_in,
    output logic [3:0]  op_a0,
    output logic [3:0]  op_b0,
    output logic [3:0]  op_a1,
    output logic [3:0]  op_b1,
    output logic [1:0]  op_sel1,
    output logic [1:0]  op_sel2,
    output logic        op_valid,
    input  logic        op_ready,
    input  logic [14:0] res_in,
    input  logic        res_valid,
    output logic [14:0] io_out,
    output logic [14:0] io_oeb,
    output logic        busy,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_MAX  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT);

    logic [19:0] sync1;
    logic [19:0] sync2;
    logic [7:0]  settle_cnt;
    logic [19:0] op_word;
    logic [19:0] last_issued;
    logic        issued_flag;
    logic [7:0]  timer;
    logic [7:0]  timer_next;
    logic        stable;
    logic        new_value;
    state_t      state;

    assign stable     = (settle_cnt == SETTLE_MAX);
    assign new_value  = !issued_flag || (sync2 != last_issued);
    assign timer_next = timer + 8'd1;

    assign op_a0   = op_word[3:0];
    assign op_b0   = op_word[7:4];
    assign op_a1   = op_word[11:8];
    assign op_b1   = op_word[15:12];
    assign op_sel1 = op_word[17:16];
    assign op_sel2 = op_word[19:18];

    // sync1 != sync2 means sync2 is about to take a different value on this edge,
    // so the settle count restarts exactly when the synchronised word changes.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1      <= '0;
            sync2      <= '0;
            settle_cnt <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
            if (sync1 != sync2) begin
                settle_cnt <= '0;
            end else if (settle_cnt != SETTLE_MAX) begin
                settle_cnt <= settle_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            op_word     <= '0;
            op_valid    <= 1'b0;
            last_issued <= '0;
            issued_flag <= 1'b0;
            timer       <= '0;
            io_out      <= '0;
            io_oeb      <= '1;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (stable && new_value) begin
                        op_word  <= sync2;
                        op_valid <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    // op_word is frozen here; later pin changes wait in the synchroniser.
                    if (op_ready) begin
                        op_valid    <= 1'b0;
                        last_issued <= op_word;
                        issued_flag <= 1'b1;
                        timer       <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer_next;
                    if (res_valid) begin
                        io_out <= res_in;
                        io_oeb <= '0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (timer_next == TIMEOUT_MAX) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    op_valid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_io_frontend.sv
// Directed bench for alu_io_frontend: a window-based reference model checked every cycle,
// plus hand-computed literal expectations for the key scenarios.
module tb_alu_io_frontend;

    localparam int SETTLE = 4;
    localparam int TMO    = 16;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic [19:0] io_in;
    logic [3:0]  op_a0, op_b0, op_a1, op_b1;
    logic [1:0]  op_sel1, op_sel2;
    logic        op_valid;
    logic        op_ready;
    logic [14:0] res_in;
    logic        res_valid;
    logic [14:0] io_out;
    logic [14:0] io_oeb;
    logic        busy;
    logic        err_timeout;

    int errors = 0;
    int checks = 0;
    int issue_cnt = 0;

    alu_io_frontend #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .io_in(io_in),
        .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
        .op_sel1(op_sel1), .op_sel2(op_sel2), .op_valid(op_valid), .op_ready(op_ready),
        .res_in(res_in), .res_valid(res_valid), .io_out(io_out), .io_oeb(io_oeb),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [19:0] pins, input logic rdy, input logic rv, input logic [14:0] res);
        io_in     = pins;
        op_ready  = rdy;
        res_valid = rv;
        res_in    = res;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge wb_clk_i);
            #2;
        end
    endtask

    task automatic waitValid(input int limit);
        int n = 0;
        while (op_valid !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        checkOutput("wait_op_valid", op_valid, 1);
    endtask

    // Reference model: s2 is the pin word two edges late; "stable" means the last
    // SETTLE+1 post-reset values of s2 are identical.
    typedef enum int {M_IDLE, M_ISSUE, M_WAIT} mstate_t;
    mstate_t     m_state;
    logic [19:0] win[$];
    logic [19:0] m_s1, m_op, m_last;
    logic        m_valid, m_issued, m_oeb, m_err, armed = 1'b0;
    logic [14:0] m_out;
    int          m_timer;

    function automatic logic win_stable();
        if (win.size() != SETTLE + 1) return 1'b0;
        foreach (win[i]) if (win[i] != win[0]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge wb_clk_i) begin
        logic        st;
        logic [19:0] s2v;
        if (wb_rst_i) begin
            armed = 1'b1;
            win = '{20'h0};
            m_s1 = '0; m_op = '0; m_last = '0; m_valid = 0; m_issued = 0;
            m_oeb = 1; m_err = 0; m_out = '0; m_timer = 0; m_state = M_IDLE;
        end else if (armed) begin
            st  = win_stable();
            s2v = win[win.size() - 1];
            case (m_state)
                M_IDLE: if (st && (!m_issued || s2v != m_last)) begin
                    m_op = s2v; m_valid = 1; m_state = M_ISSUE;
                end
                M_ISSUE: if (op_ready) begin
                    m_valid = 0; m_last = m_op; m_issued = 1; m_timer = 0; m_state = M_WAIT;
                end
                M_WAIT: begin
                    m_timer++;
                    if (res_valid) begin
                        m_out = res_in; m_oeb = 0; m_state = M_IDLE;
                    end else if (m_timer == TMO) begin
                        m_err = 1; m_state = M_IDLE;
                    end
                end
                default: m_state = M_IDLE;
            endcase
            win.push_back(m_s1);
            m_s1 = io_in;
            if (win.size() > SETTLE + 1) win.delete(0);
        end
    end

    always @(negedge wb_clk_i) begin
        if (armed) begin
            checkOutput("m_op_valid", op_valid, m_valid);
            checkOutput("m_busy", busy, m_state != M_IDLE);
            checkOutput("m_io_out", io_out, m_out);
            checkOutput("m_io_oeb", io_oeb, m_oeb ? 15'h7FFF : 15'h0);
            checkOutput("m_err_timeout", err_timeout, m_err);
            if (m_valid) checkOutput("m_op_word", {op_sel2, op_sel1, op_b1, op_a1, op_b0, op_a0}, m_op);
        end
    end

    logic prev_valid = 1'b0;
    always @(negedge wb_clk_i) begin
        if (op_valid === 1'b1 && prev_valid !== 1'b1) issue_cnt++;
        prev_valid = op_valid;
    end

    initial begin
        int base;
        wb_rst_i = 1'b1;
        applyStimulus(20'h00099, 1'b1, 1'b0, 15'h0);
        repeat (3) @(posedge wb_clk_i);
        #2;
        wb_rst_i = 1'b0;
        checkOutput("reset_op_valid", op_valid, 0);
        checkOutput("reset_io_oeb", io_oeb, 15'h7FFF);
        checkOutput("reset_busy", busy, 0);

        // Basic issue: op_valid rises on edge 7 after the pins settle
        tick(6);
        checkOutput("basic_no_early_issue", op_valid, 0);
        tick(1);
        checkOutput("basic_op_valid", op_valid, 1);
        checkOutput("basic_a0", op_a0, 9);
        checkOutput("basic_b0", op_b0, 9);
        checkOutput("basic_a1b1sel", {op_sel2, op_sel1, op_b1, op_a1}, 0);
        tick(1);
        checkOutput("basic_handshake_valid", op_valid, 0);
        checkOutput("basic_wait_busy", busy, 1);
        applyStimulus(20'h00099, 1'b1, 1'b1, 15'b001000000010101);
        tick(1);
        checkOutput("basic_io_out", io_out, 15'b001000000010101);
        checkOutput("basic_io_oeb", io_oeb, 0);
        checkOutput("basic_busy_idle", busy, 0);
        applyStimulus(20'h00099, 1'b1, 1'b0, 15'h0);

        // Debounce: 2-cycle glitch is ignored, an 8-cycle hold issues once
        base = issue_cnt;
        applyStimulus(20'h00098, 1'b1, 1'b0, 15'h0);
        tick(2);
        applyStimulus(20'h00099, 1'b1, 1'b0, 15'h0);
        tick(12);
        checkOutput("glitch_no_issue", issue_cnt - base, 0);
        applyStimulus(20'h00098, 1'b1, 1'b0, 15'h0);
        tick(8);
        checkOutput("hold_one_issue", issue_cnt - base, 1);
        applyStimulus(20'h00098, 1'b1, 1'b1, 15'h1234);
        tick(1);
        checkOutput("debounce_io_out", io_out, 15'h1234);
        applyStimulus(20'h00098, 1'b1, 1'b0, 15'h0);

        // Backpressure: operands frozen while op_ready is low
        applyStimulus(20'h00055, 1'b0, 1'b0, 15'h0);
        waitValid(20);
        applyStimulus(20'hF0000, 1'b0, 1'b0, 15'h0);
        for (int i = 0; i < 10; i++) begin
            tick(1);
            checkOutput("bp_hold_word", {op_sel2, op_sel1, op_b1, op_a1, op_b0, op_a0}, 20'h00055);
        end
        applyStimulus(20'hF0000, 1'b1, 1'b0, 15'h0);
        tick(1);
        checkOutput("bp_handshake", op_valid, 0);
        applyStimulus(20'hF0000, 1'b1, 1'b1, 15'h0ABC);
        tick(1);
        applyStimulus(20'hF0000, 1'b1, 1'b0, 15'h0);
        tick(1);
        checkOutput("bp_second_issue", op_valid, 1);
        checkOutput("bp_second_sel", {op_sel2, op_sel1}, 4'hF);
        checkOutput("bp_second_ops", {op_b1, op_a1, op_b0, op_a0}, 0);
        tick(1);

        // Timeout: no response after the handshake
        tick(15);
        checkOutput("tmo_not_yet", err_timeout, 0);
        tick(1);
        checkOutput("tmo_err", err_timeout, 1);
        checkOutput("tmo_io_out_kept", io_out, 15'h0ABC);
        tick(3);
        checkOutput("tmo_sticky", err_timeout, 1);
        applyStimulus(20'h12345, 1'b1, 1'b0, 15'h0);
        waitValid(20);
        checkOutput("tmo_next_issue", {op_sel2, op_sel1, op_b1, op_a1, op_b0, op_a0}, 20'h12345);
        tick(1);

        // Mid-operation reset while in WAIT
        wb_rst_i = 1'b1;
        tick(1);
        wb_rst_i = 1'b0;
        checkOutput("rst_io_out", io_out, 0);
        checkOutput("rst_io_oeb", io_oeb, 15'h7FFF);
        checkOutput("rst_err", err_timeout, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_op_word", {op_sel2, op_sel1, op_b1, op_a1, op_b0, op_a0}, 0);
        tick(6);
        checkOutput("rst_no_early_issue", op_valid, 0);
        tick(1);
        checkOutput("rst_reissue", op_valid, 1);
        checkOutput("rst_reissue_a0", op_a0, 5);
        tick(1);

        // Same-edge race: result arrives exactly on the timeout edge
        tick(15);
        checkOutput("race_busy", busy, 1);
        applyStimulus(20'h12345, 1'b1, 1'b1, 15'h5A5A);
        tick(1);
        applyStimulus(20'h12345, 1'b1, 1'b0, 15'h0);
        checkOutput("race_err", err_timeout, 0);
        checkOutput("race_io_out", io_out, 15'h5A5A);
        checkOutput("race_io_oeb", io_oeb, 0);
        tick(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
